// File: rtl/conv_mac_sequencer.sv
// conv_mac_sequencer
// Control FSM for the convolution Z[i] = sum_j X[i-j]*Y[j], i = 0 .. sizeX+sizeY-2.
// Drives the X/Y read addresses, the MAC clear/enable pair and the Z write strobe.
// All outputs are registered, so each output value belongs to the state being entered.
// Build macro CONV_SEQ_TAP_SKIP_EN: sweep only the valid j window of each output
// instead of the full 0..sizeY-1 sweep with invalid taps gated off.
module conv_mac_sequencer #(
    parameter int ADDR_WIDTH_X = 5,
    parameter int ADDR_WIDTH_Y = 5,
    parameter int ADDR_WIDTH_Z = 6
) (
    input  logic                    clk,
    input  logic                    rst_a,
    input  logic                    start,
    input  logic [ADDR_WIDTH_X-1:0] sizeX,
    input  logic [ADDR_WIDTH_Y-1:0] sizeY,
    output logic [ADDR_WIDTH_X-1:0] memX_addr,
    output logic [ADDR_WIDTH_Y-1:0] memY_addr,
    output logic                    mac_clear,
    output logic                    mac_en,
    output logic                    writeZ,
    output logic [ADDR_WIDTH_Z-1:0] memZ_addr,
    output logic                    busy,
    output logic                    done
);
    // k = i - j needs one sign bit above the Z address range
    localparam int KW = ADDR_WIDTH_Z + 1;
    localparam logic [KW-1:0]           ONE_K = KW'(1);
    localparam logic [KW-1:0]           TWO_K = KW'(2);
    localparam logic [ADDR_WIDTH_Y-1:0] ONE_Y = ADDR_WIDTH_Y'(1);
    localparam logic [ADDR_WIDTH_Z-1:0] ONE_Z = ADDR_WIDTH_Z'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_LOOP, S_DRAIN, S_WRITE, S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH_X-1:0] size_x_q, size_x_d;
    logic [ADDR_WIDTH_Y-1:0] size_y_q, size_y_d;
    logic [ADDR_WIDTH_Z-1:0] i_q, i_d;
    logic [ADDR_WIDTH_Y-1:0] j_q, j_d;
    logic                    tap_q, tap_d;      // validity of the tap addressed this cycle
    logic [ADDR_WIDTH_X-1:0] memx_addr_q, memx_addr_d;
    logic [ADDR_WIDTH_Y-1:0] memy_addr_q, memy_addr_d;
    logic [ADDR_WIDTH_Z-1:0] memz_addr_q, memz_addr_d;
    logic mac_clear_q, mac_clear_d, mac_en_q, mac_en_d, write_z_q, write_z_d;
    logic busy_q, busy_d, done_q, done_d;

    logic [ADDR_WIDTH_Y-1:0] j_first, j_last, j_step;
    logic signed [KW-1:0]    k_first, k_step;
    logic                    last_i;

    // Signed X index for tap (i, j); negative means before X[0]
    function automatic logic signed [KW-1:0] tap_index(input logic [ADDR_WIDTH_Z-1:0] ii,
                                                       input logic [ADDR_WIDTH_Y-1:0] jj);
        return signed'(KW'(ii)) - signed'(KW'(jj));
    endfunction

    // A tap is real only when 0 <= k < sizeX; the full-width compare avoids address aliasing
    function automatic logic tap_in_range(input logic signed [KW-1:0] k,
                                          input logic [ADDR_WIDTH_X-1:0] sx);
        return !k[KW-1] && (k < signed'(KW'(sx)));
    endfunction

    // j window of the current output and the taps at its start and at the next step
    always_comb begin
        j_first = '0;
        j_last  = size_y_q - ONE_Y;
`ifdef CONV_SEQ_TAP_SKIP_EN
        if (KW'(i_q) >= KW'(size_x_q))
            j_first = ADDR_WIDTH_Y'(KW'(i_q) - KW'(size_x_q) + ONE_K);
        if (KW'(i_q) < KW'(size_y_q - ONE_Y))
            j_last = ADDR_WIDTH_Y'(i_q);
`endif
        j_step  = j_q + ONE_Y;
        k_first = tap_index(i_q, j_first);
        k_step  = tap_index(i_q, j_step);
        last_i  = (KW'(i_q) == (KW'(size_x_q) + KW'(size_y_q) - TWO_K));
    end

    // Next state, counters and next registered outputs
    always_comb begin
        state_d     = state_q;
        size_x_d    = size_x_q;
        size_y_d    = size_y_q;
        i_d         = i_q;
        j_d         = j_q;
        tap_d       = tap_q;
        memx_addr_d = memx_addr_q;
        memy_addr_d = memy_addr_q;
        memz_addr_d = memz_addr_q;
        mac_clear_d = 1'b0;
        mac_en_d    = 1'b0;
        write_z_d   = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    size_x_d = sizeX;
                    size_y_d = sizeY;
                    if ((sizeX == '0) || (sizeY == '0)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = S_CLEAR;
                        i_d         = '0;
                        mac_clear_d = 1'b1;
                        busy_d      = 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                state_d     = S_LOOP;
                busy_d      = 1'b1;
                j_d         = j_first;
                memy_addr_d = j_first;
                memx_addr_d = k_first[ADDR_WIDTH_X-1:0];
                tap_d       = tap_in_range(k_first, size_x_q);
            end
            S_LOOP: begin
                busy_d   = 1'b1;
                mac_en_d = tap_q;   // read data for this cycle's address arrives next cycle
                if (j_q == j_last) begin
                    state_d = S_DRAIN;
                    tap_d   = 1'b0;
                end else begin
                    j_d         = j_step;
                    memy_addr_d = j_step;
                    memx_addr_d = k_step[ADDR_WIDTH_X-1:0];
                    tap_d       = tap_in_range(k_step, size_x_q);
                end
            end
            S_DRAIN: begin
                state_d     = S_WRITE;
                busy_d      = 1'b1;
                write_z_d   = 1'b1;
                memz_addr_d = i_q;
            end
            S_WRITE: begin
                if (last_i) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d     = S_CLEAR;
                    i_d         = i_q + ONE_Z;
                    mac_clear_d = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters and output registers; reset aborts any job immediately
    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            state_q     <= S_IDLE;
            size_x_q    <= '0;
            size_y_q    <= '0;
            i_q         <= '0;
            j_q         <= '0;
            tap_q       <= 1'b0;
            memx_addr_q <= '0;
            memy_addr_q <= '0;
            memz_addr_q <= '0;
            mac_clear_q <= 1'b0;
            mac_en_q    <= 1'b0;
            write_z_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            size_x_q    <= size_x_d;
            size_y_q    <= size_y_d;
            i_q         <= i_d;
            j_q         <= j_d;
            tap_q       <= tap_d;
            memx_addr_q <= memx_addr_d;
            memy_addr_q <= memy_addr_d;
            memz_addr_q <= memz_addr_d;
            mac_clear_q <= mac_clear_d;
            mac_en_q    <= mac_en_d;
            write_z_q   <= write_z_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign memX_addr = memx_addr_q;
    assign memY_addr = memy_addr_q;
    assign memZ_addr = memz_addr_q;
    assign mac_clear = mac_clear_q;
    assign mac_en    = mac_en_q;
    assign writeZ    = write_z_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// tb_conv_mac_sequencer
// Directed bench for conv_mac_sequencer. A per-cycle schedule built from the
// convolution timing rules is compared against the DUT on every negedge, and a
// bench-side X/Y memory + MAC + Z memory model produces the Z values that are
// compared against a direct convolution sum and against hand-computed literals.
// Honours CONV_SEQ_TAP_SKIP_EN when the design is built with it.
`timescale 1ns/1ps
module tb_conv_mac_sequencer;
    localparam int AX = 5;
    localparam int AY = 5;
    localparam int AZ = 6;

    logic          clk = 1'b0;
    logic          rst_a = 1'b1;
    logic          start = 1'b0;
    logic [AX-1:0] sizeX = '0;
    logic [AY-1:0] sizeY = '0;
    logic [AX-1:0] memX_addr;
    logic [AY-1:0] memY_addr;
    logic          mac_clear, mac_en, writeZ, busy, done;
    logic [AZ-1:0] memZ_addr;

    conv_mac_sequencer #(.ADDR_WIDTH_X(AX), .ADDR_WIDTH_Y(AY), .ADDR_WIDTH_Z(AZ)) dut (
        .clk(clk), .rst_a(rst_a), .start(start), .sizeX(sizeX), .sizeY(sizeY),
        .memX_addr(memX_addr), .memY_addr(memY_addr), .mac_clear(mac_clear),
        .mac_en(mac_en), .writeZ(writeZ), .memZ_addr(memZ_addr), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          busy;
        logic          clr;
        logic          en;
        logic          wz;
        logic          done;
        logic [AZ-1:0] zaddr;
    } rec_t;

    rec_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   busy_cnt = 0, wz_cnt = 0, clr_cnt = 0, done_cnt = 0, cur_len = 0, last_zaddr = 0;
    int   per_len[$];

    int xv[32], yv[32];
    int xmem[32], ymem[32];
    int zmem[64];
    int rd_x = 0, rd_y = 0, acc = 0;

    // Synchronous X/Y memories, the external MAC and the Z memory
    always @(posedge clk) begin
        rd_x <= xmem[memX_addr];
        rd_y <= ymem[memY_addr];
        if (mac_clear) acc <= 0;
        else if (mac_en) acc <= acc + rd_x * rd_y;
        if (writeZ) zmem[memZ_addr] <= acc;
    end

    function automatic bit tap(input int i, input int j, input int sx);
        return (i - j >= 0) && (i - j < sx);
    endfunction

    function automatic rec_t mk(input bit b, input bit c, input bit e, input bit w,
                                input bit d, input int z);
        rec_t r;
        r.busy = b; r.clr = c; r.en = e; r.wz = w; r.done = d; r.zaddr = AZ'(z);
        return r;
    endfunction

    // Expected cycle schedule of one job, from the cycle after start is sampled
    task automatic push_job(input int sx, input int sy);
        int jlo, jhi;
        if (sx == 0 || sy == 0) begin
            exp_q.push_back(mk(0, 0, 0, 0, 1, 0));
            return;
        end
        for (int i = 0; i <= sx + sy - 2; i++) begin
`ifdef CONV_SEQ_TAP_SKIP_EN
            jlo = (i - sx + 1 > 0) ? i - sx + 1 : 0;
            jhi = (i < sy - 1) ? i : sy - 1;
`else
            jlo = 0;
            jhi = sy - 1;
`endif
            exp_q.push_back(mk(1, 1, 0, 0, 0, 0));
            for (int j = jlo; j <= jhi; j++)
                exp_q.push_back(mk(1, 0, (j == jlo) ? 1'b0 : tap(i, j - 1, sx), 0, 0, 0));
            exp_q.push_back(mk(1, 0, tap(i, jhi, sx), 0, 0, 0));
            exp_q.push_back(mk(1, 0, 0, 1, 0, i));
        end
        exp_q.push_back(mk(0, 0, 0, 0, 1, 0));
    endtask

    // Compare process: statistics every cycle, schedule check while a schedule is pending
    initial begin
        rec_t e;
        forever begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (mac_clear) begin
                clr_cnt++;
                cur_len = 1;
            end else if (busy) begin
                cur_len++;
            end
            if (writeZ) begin
                wz_cnt++;
                last_zaddr = int'(memZ_addr);
                per_len.push_back(cur_len);
            end
            if (done) done_cnt++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({busy, mac_clear, mac_en, writeZ, done} !== {e.busy, e.clr, e.en, e.wz, e.done} ||
                    (e.wz && (memZ_addr !== e.zaddr))) begin
                    failures++;
                    $display("FAIL cycle_trace t=%0t busy/clr/en/wz/done got %b%b%b%b%b zaddr %0d, need %b%b%b%b%b zaddr %0d",
                             $time, busy, mac_clear, mac_en, writeZ, done, memZ_addr,
                             e.busy, e.clr, e.en, e.wz, e.done, e.zaddr);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got %0d need %0d", name, act, req);
        end
    endtask

    task automatic load_mem(input int sx, input int sy);
        for (int n = 0; n < 32; n++) begin
            xmem[n] = (n < sx) ? xv[n] : 1000 + n;
            ymem[n] = (n < sy) ? yv[n] : 2000 + n;
        end
    endtask

    // Present start for one IDLE cycle (or keep it held) and queue the schedule
    task automatic launch(input int sx, input int sy, input bit hold);
        @(posedge clk); #1;
        sizeX = AX'(sx);
        sizeY = AY'(sy);
        start = 1'b1;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
        push_job(sx, sy);
        if (!hold) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
    endtask

    task automatic wait_idle(input int max_cycles);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < max_cycles) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL job_timeout got %0d pending cycles need 0", exp_q.size());
            exp_q.delete();
        end
        #1;
    endtask

    task automatic check_z(input string name, input int sx, input int sy);
        int s;
        for (int i = 0; i <= sx + sy - 2; i++) begin
            s = 0;
            for (int j = 0; j < sy; j++)
                if (i - j >= 0 && i - j < sx) s += xv[i - j] * yv[j];
            chk($sformatf("%s_z%0d", name, i), zmem[i], s);
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog got timeout need finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, w0, d0, c0, p0, n;
        int len1[4];
        for (int n2 = 0; n2 < 32; n2++) begin
            xv[n2] = 0;
            yv[n2] = 0;
        end
        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ctrl", int'({mac_clear, mac_en, writeZ}), 0);
        chk("rst_addr", int'({memX_addr, memY_addr, memZ_addr}), 0);
        rst_a = 1'b0;

        // 3x2 job, X=1,2,3 Y=4,5
        xv[0] = 1; xv[1] = 2; xv[2] = 3; yv[0] = 4; yv[1] = 5;
        load_mem(3, 2);
        b0 = busy_cnt; w0 = wz_cnt; p0 = per_len.size();
        launch(3, 2, 0);
        wait_idle(200);
`ifdef CONV_SEQ_TAP_SKIP_EN
        chk("s1_busy_cycles", busy_cnt - b0, 18);
        len1 = '{4, 5, 5, 4};
`else
        chk("s1_busy_cycles", busy_cnt - b0, 20);
        len1 = '{5, 5, 5, 5};
`endif
        chk("s1_writes", wz_cnt - w0, 4);
        chk("s1_last_zaddr", last_zaddr, 3);
        for (int k = 0; k < 4; k++)
            chk($sformatf("s1_out_len%0d", k), (per_len.size() > p0 + k) ? per_len[p0 + k] : -1, len1[k]);
        chk("s1_z0", zmem[0], 4);
        chk("s1_z1", zmem[1], 13);
        chk("s1_z2", zmem[2], 22);
        chk("s1_z3", zmem[3], 15);
        check_z("s1", 3, 2);

        // zero sizes finish straight away
        b0 = busy_cnt; w0 = wz_cnt; d0 = done_cnt;
        launch(0, 3, 0);
        wait_idle(20);
        launch(4, 0, 0);
        wait_idle(20);
        chk("zero_busy_cycles", busy_cnt - b0, 0);
        chk("zero_writes", wz_cnt - w0, 0);
        chk("zero_dones", done_cnt - d0, 2);

        // 31x31 full size
        for (int n2 = 0; n2 < 31; n2++) begin
            xv[n2] = (n2 % 7) + 1;
            yv[n2] = (n2 % 5) + 1;
        end
        load_mem(31, 31);
        b0 = busy_cnt; w0 = wz_cnt;
        launch(31, 31, 0);
        wait_idle(3000);
`ifdef CONV_SEQ_TAP_SKIP_EN
        chk("big_busy_cycles", busy_cnt - b0, 1144);
`else
        chk("big_busy_cycles", busy_cnt - b0, 2074);
`endif
        chk("big_writes", wz_cnt - w0, 61);
        chk("big_last_zaddr", last_zaddr, 60);
        check_z("big", 31, 31);

        // start held and sizes changed mid-job; relaunch only from IDLE after done
        for (int n2 = 0; n2 < 32; n2++) begin
            xv[n2] = 0;
            yv[n2] = 0;
        end
        xv[0] = 1; xv[1] = 2; xv[2] = 3; yv[0] = 4; yv[1] = 5;
        load_mem(3, 2);
        b0 = busy_cnt; w0 = wz_cnt; d0 = done_cnt;
        launch(3, 2, 1);
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
        push_job(2, 2);
        @(posedge clk); #1;
        sizeX = AX'(2);
        sizeY = AY'(2);
        n = 0;
        while (done_cnt == d0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle(200);
`ifdef CONV_SEQ_TAP_SKIP_EN
        chk("mid_busy_cycles", busy_cnt - b0, 31);
`else
        chk("mid_busy_cycles", busy_cnt - b0, 35);
`endif
        chk("mid_writes", wz_cnt - w0, 7);
        chk("mid_dones", done_cnt - d0, 2);
        chk("mid_z0", zmem[0], 4);
        chk("mid_z1", zmem[1], 13);
        chk("mid_z2", zmem[2], 10);

        // reset during LOOP of i=2
        load_mem(3, 2);
        c0 = clr_cnt; d0 = done_cnt; w0 = wz_cnt;
        launch(3, 2, 0);
        n = 0;
        while (clr_cnt - c0 < 3 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("abort_reached_i2", clr_cnt - c0, 3);
        #1;
        rst_a = 1'b1;
        exp_q.delete();
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_ctrl", int'({mac_clear, mac_en, writeZ, done}), 0);
        chk("abort_addr", int'({memX_addr, memY_addr, memZ_addr}), 0);
        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_writes", wz_cnt - w0, 2);
        chk("abort_no_done", done_cnt - d0, 0);

        // fresh 2x2 job after reset
        load_mem(2, 2);
        w0 = wz_cnt;
        launch(2, 2, 0);
        wait_idle(200);
        chk("post_writes", wz_cnt - w0, 3);
        chk("post_last_zaddr", last_zaddr, 2);
        chk("post_z2", zmem[2], 10);
        check_z("post", 2, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
